// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and screen bounds for the video path
package vga_pkg;
    localparam int COORD_W = 10;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP = 33;
    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides the board clock down to a one-clk pixel strobe
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    logic [3:0] div;
    logic [3:0] div_next;
    assign div_next = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    // Strobe is registered from div_next so it is low in reset even when CLK_DIV=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= 4'd0;
            pixel_tick <= 1'b0;
        end else begin
            div <= div_next;
            pixel_tick <= (div_next == DIV_LAST);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v counters, sync and video_on decode for VGA timing
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               pixel_tick,
    output logic               frame_start,
    output logic [7:0]         frame_count
);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_ACT = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic h_wrap;
    logic v_wrap;
    logic frame_wrap;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .pixel_tick(pixel_tick)
    );

    assign h_wrap = (x == H_LAST);
    assign v_wrap = (y == V_LAST);
    assign frame_wrap = pixel_tick && h_wrap && v_wrap;
    assign x_next = pixel_tick ? (h_wrap ? '0 : x + 1'b1) : x;
    assign y_next = (pixel_tick && h_wrap) ? (v_wrap ? '0 : y + 1'b1) : y;

    // Decode from next-state counts so the qualifiers line up with the x/y they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            video_on <= 1'b1;
            hsync <= 1'b1;
            vsync <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            x <= x_next;
            y <= y_next;
            video_on <= (x_next < H_ACT) && (y_next < V_ACT);
            hsync <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync <= !((y_next >= VS_START) && (y_next < VS_END));
            frame_start <= frame_wrap;
            if (frame_wrap) frame_count <= frame_count + 8'd1;
        end
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the board clock. It produces the pixel coordinates `x`/`y` that every glyph, paddle and ball renderer in the pong display path compares against its own `start_x`/`start_y`. It also drives the `hsync`/`vsync` pins and gives the colour mux a `video_on` qualifier. It sits at the head of the video pipeline; all shape/char blocks are downstream consumers of its outputs.

## Interface
Parameters:
- `CLK_DIV`, 4, board clocks per pixel (100 MHz → 25 MHz pixel rate); legal range 1..16
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, hsync pulse width, pixels
- `H_BP`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch, lines
- `V_SYNC`, 2, vsync pulse width, lines
- `V_BP`, 33, vertical back porch, lines

Ports:
- `clk` in 1: board clock; one clock domain only
- `rst_n` in 1: reset, asynchronous assert, active-low
- `x` out 10: current horizontal count, 0..H_TOTAL-1
- `y` out 10: current vertical count, 0..V_TOTAL-1
- `video_on` out 1: high when x < H_ACTIVE and y < V_ACTIVE
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `pixel_tick` out 1: one-`clk` strobe; counters advance on the edge following it
- `frame_start` out 1: one-`clk` pulse when the counters wrap to (0,0)
- `frame_count` out 8: frames completed since reset, wraps 255→0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024, so 10-bit counters suffice with no overflow.
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = 1 when `div` == CLK_DIV-1. With CLK_DIV=1, `pixel_tick` is constantly 1 after reset.
- Behaviour on the edge where `pixel_tick` is high:
  - if x == H_TOTAL-1: x←0
    - if y == V_TOTAL-1: y←0, `frame_count`++
    - else: y++
  - else: x++
- `hsync` = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
- `vsync` = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491.
- `video_on`, `hsync` and `vsync` are registered. They are computed from next-state counter values, so they always describe the x/y shown in the same cycle, with no skew.
- `frame_start` is registered and is high exactly in the cycle where x==0 and y==0 first appear after a wrap. It is not asserted out of reset.
- Reset values: x=0, y=0, `div`=0, `video_on`=1, `hsync`=1, `vsync`=1, `pixel_tick`=0, `frame_start`=0, `frame_count`=0.
- Reset asserted mid-frame: all state returns to the reset values immediately (asynchronously). Counting resumes from (0,0) with a full CLK_DIV-clk first pixel after release.

## Timing
- Each (x,y) value is held for exactly CLK_DIV clk cycles.
- Line = H_TOTAL·CLK_DIV clk (3200).
- Frame = H_TOTAL·V_TOTAL·CLK_DIV clk (1 680 000).
- Downstream char/shape blocks are combinational on x/y. Their `display` output is valid within the same pixel period, and the colour mux samples it on the next `pixel_tick`. Total pipeline delay from x/y to the RGB pins is therefore 1 pixel.
- hsync low width = H_SYNC·CLK_DIV clk. vsync low width = V_SYNC lines.

## Structure
- Shared package `vga_pkg`:
  - default timing constants: H_/V_ ACTIVE/FP/SYNC/BP
  - derived H_TOTAL/V_TOTAL
  - coordinate width constant (10)
  
  The renderers use the same package for screen bounds.
- One sub-module, `pixel_tick_gen` (the `div` counter plus strobe, parameter CLK_DIV). The h/v counters, decode and output registers live in the top module.

## Test plan
- Reset, then release with CLK_DIV=4 → `pixel_tick` first high on clk 4 after release, then every 4 clk. x steps 0→1 on the following edge. All reset values are checked during reset.
- Run one line → x reaches 799, then wraps to 0 while y goes 0→1. `hsync` is low for exactly 384 clk, starting when x becomes 656. `video_on` falls when x becomes 640.
- Run to line 489→490 → `vsync` falls with y=490 and rises with y=492. `video_on` is low for all of y ≥ 480.
- Run two full frames → `frame_start` pulses exactly twice, 1 680 000 clk apart, each coinciding with (0,0). `frame_count` reads 1 then 2. Force `frame_count`=255 and run a frame → wraps to 0.
- Assert `rst_n` low at (x=300, y=200) mid-pixel → outputs reach their reset values without waiting for a clk edge. After release, the sequence matches the first scenario.
- CLK_DIV=1 → `pixel_tick` is stuck high, x advances every clk, and the line length is 800 clk.
